// File: rtl/dmem_responder.sv
// dmem_responder
//   Slave end of the dmem request/response protocol. It accepts one
//   word-aligned read or byte-masked write at a time while idle, holds it for
//   a fixed latency, then pulses dmem_resp for one cycle. A read returns the
//   full stored word; the core extracts sub-word data using addr[1:0].
//
// Parameters
//   ADDR_BITS : log2 of the storage depth in 32-bit words (higher addr bits alias)
//   READ_LAT  : request-to-response cycles for reads  (1..15)
//   WRITE_LAT : request-to-response cycles for writes (1..15)
//
// Ports
//   clk        in   clock
//   rst        in   synchronous active-high reset (control state and rdata_q only)
//   flush      in   mispredict flush; cancels a pending read, never a write
//   dmem_addr  in   byte address, word index = dmem_addr[ADDR_BITS+1:2]
//   dmem_rmask in   nonzero = read request
//   dmem_wmask in   byte-enable write request (takes priority over rmask)
//   dmem_wdata in   write data, byte lanes aligned to the word
//   dmem_rdata out  read word, valid with dmem_resp on a read, else 0
//   dmem_resp  out  one-cycle completion pulse
//   busy       out  high whenever a transaction is in flight
module dmem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        busy
);

    localparam logic [3:0] RD_L = 4'(READ_LAT);
    localparam logic [3:0] WR_L = 4'(WRITE_LAT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        kind_q, kind_d;    // 1 = write in flight, 0 = read
    logic [31:0] rdata_q;

    logic [31:0] mem [0:(1<<ADDR_BITS)-1];
    logic [ADDR_BITS-1:0] idx;

    logic wr_req, rd_acc, wr_acc, read_flush;
    logic [3:0] lat;

    // Bits that only alias or select sub-word lanes inside the core.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{dmem_addr[31:ADDR_BITS+2], dmem_addr[1:0]};

    // Byte-lane merge of new write data into an existing word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    assign idx    = dmem_addr[ADDR_BITS+1:2];
    assign wr_req = |dmem_wmask;
    // Writes are accepted even under flush; reads arriving with flush are dropped.
    assign wr_acc = (state_q == S_IDLE) && wr_req;
    assign rd_acc = (state_q == S_IDLE) && !wr_req && (|dmem_rmask) && !flush;
    // Flush only affects an in-flight read.
    assign read_flush = flush && !kind_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kind_d  = kind_q;
        lat     = RD_L;
        unique case (state_q)
            S_IDLE: begin
                if (wr_acc || rd_acc) begin
                    kind_d = wr_acc;
                    lat    = wr_acc ? WR_L : RD_L;
                    if (lat == 4'd1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = lat - 4'd1;
                    end
                end
            end
            S_WAIT: begin
                if (read_flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = S_RESP;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            kind_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
        end
    end

    // Storage is never cleared; a write commits at its accept edge.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) mem[idx] <= merge_bytes(mem[idx], dmem_wdata, dmem_wmask);
    end

    always_ff @(posedge clk) begin
        if (rst)         rdata_q <= 32'h0;
        else if (rd_acc) rdata_q <= mem[idx];
    end

    assign busy       = (state_q != S_IDLE);
    // Flush gating of the response is the only combinational input path.
    assign dmem_resp  = (state_q == S_RESP) && !read_flush;
    assign dmem_rdata = (state_q == S_RESP && !kind_q) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_rmask, dmem_wmask;
    logic [31:0] rdata_a, rdata_b;
    logic        resp_a, resp_b, busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // dut_a: READ_LAT=2, WRITE_LAT=1; dut_b: READ_LAT=3, WRITE_LAT=2. Shared stimulus.
    dmem_responder #(.ADDR_BITS(10), .READ_LAT(2), .WRITE_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .dmem_addr(dmem_addr),
        .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
        .dmem_rdata(rdata_a), .dmem_resp(resp_a), .busy(busy_a));

    dmem_responder #(.ADDR_BITS(10), .READ_LAT(3), .WRITE_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .dmem_addr(dmem_addr),
        .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
        .dmem_rdata(rdata_b), .dmem_resp(resp_b), .busy(busy_b));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Presents a request for one cycle; returns in cycle T+1.
    task automatic present(input logic [31:0] a, input logic [3:0] rm,
                           input logic [3:0] wm, input logic [31:0] wd);
        dmem_addr = a; dmem_rmask = rm; dmem_wmask = wm; dmem_wdata = wd;
        tick();
        dmem_rmask = 4'h0; dmem_wmask = 4'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        dmem_addr = 32'h0; dmem_rmask = 4'h0; dmem_wmask = 4'h0; dmem_wdata = 32'h0;
        idle(3);
        rst = 1'b0;
        tick();
        checks++;
        if ({resp_a, busy_a, rdata_a} !== 34'h0) begin
            errors++; $display("FAIL reset_a: resp=%b busy=%b rdata=%h, want 0/0/0", resp_a, busy_a, rdata_a);
        end
        checks++;
        if ({resp_b, busy_b, rdata_b} !== 34'h0) begin
            errors++; $display("FAIL reset_b: resp=%b busy=%b rdata=%h, want 0/0/0", resp_b, busy_b, rdata_b);
        end
    endtask

    task automatic test_write_read();
        present(32'h40, 4'h0, 4'hF, 32'hDEADBEEF);
        checks++;
        if (resp_a !== 1'b1 || busy_a !== 1'b1 || rdata_a !== 32'h0) begin
            errors++; $display("FAIL wr_resp_T1: resp=%b busy=%b rdata=%h, want 1/1/0", resp_a, busy_a, rdata_a);
        end
        tick();
        checks++;
        if (resp_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++; $display("FAIL wr_done_T2: resp=%b busy=%b, want 0/0", resp_a, busy_a);
        end
        idle(3);
        present(32'h40, 4'hF, 4'h0, 32'h0);
        checks++;
        if (resp_a !== 1'b0 || busy_a !== 1'b1) begin
            errors++; $display("FAIL rd_wait_T1: resp=%b busy=%b, want 0/1", resp_a, busy_a);
        end
        tick();
        checks++;
        if (resp_a !== 1'b1 || busy_a !== 1'b1 || rdata_a !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rd_resp_T2: resp=%b busy=%b rdata=%h, want 1/1/deadbeef", resp_a, busy_a, rdata_a);
        end
        tick();
        checks++;
        if (resp_a !== 1'b0 || busy_a !== 1'b0 || rdata_a !== 32'h0) begin
            errors++; $display("FAIL rd_done_T3: resp=%b busy=%b rdata=%h, want 0/0/0", resp_a, busy_a, rdata_a);
        end
        idle(3);
    endtask

    task automatic test_byte_merge();
        present(32'h42, 4'h0, 4'b0100, 32'h00AA0000);
        idle(4);
        present(32'h41, 4'hF, 4'h0, 32'h0);
        tick();
        checks++;
        if (resp_a !== 1'b1 || rdata_a !== 32'hDEAABEEF) begin
            errors++; $display("FAIL byte_merge: resp=%b rdata=%h, want 1/deaabeef", resp_a, rdata_a);
        end
        idle(4);
    endtask

    task automatic test_req_while_busy();
        int nresp;
        nresp = 0;
        present(32'h40, 4'hF, 4'h0, 32'h0);
        // Hold a second read at 0x80 through WAIT and RESP of dut_a.
        dmem_addr = 32'h80; dmem_rmask = 4'hF;
        for (int i = 0; i < 2; i++) begin
            nresp += int'(resp_a);
            tick();
        end
        dmem_rmask = 4'h0;
        for (int i = 0; i < 4; i++) begin
            nresp += int'(resp_a);
            tick();
        end
        checks++;
        if (nresp != 1) begin
            errors++; $display("FAIL busy_ignore: resp_count=%0d, want 1", nresp);
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++; $display("FAIL busy_ignore_idle: busy=%b, want 0", busy_a);
        end
    endtask

    task automatic test_flush_read();
        int nresp;
        present(32'h40, 4'hF, 4'h0, 32'h0);
        flush = 1'b1;                 // dut_b is in WAIT (cnt=2)
        tick();
        flush = 1'b0;
        checks++;
        if (busy_b !== 1'b0 || resp_b !== 1'b0) begin
            errors++; $display("FAIL flush_wait: busy=%b resp=%b, want 0/0", busy_b, resp_b);
        end
        nresp = 0;
        for (int i = 0; i < 3; i++) begin
            nresp += int'(resp_b);
            tick();
        end
        checks++;
        if (nresp != 0) begin
            errors++; $display("FAIL flush_wait_noresp: resp_count=%0d, want 0", nresp);
        end
        idle(2);
        present(32'h40, 4'hF, 4'h0, 32'h0);
        idle(2);                      // dut_b now in RESP
        flush = 1'b1;
        #1;
        checks++;
        if (resp_b !== 1'b0 || busy_b !== 1'b1) begin
            errors++; $display("FAIL flush_resp: resp=%b busy=%b, want 0/1", resp_b, busy_b);
        end
        tick();
        flush = 1'b0;
        checks++;
        if (resp_b !== 1'b0 || busy_b !== 1'b0) begin
            errors++; $display("FAIL flush_resp_after: resp=%b busy=%b, want 0/0", resp_b, busy_b);
        end
        idle(3);
    endtask

    task automatic test_flush_write();
        present(32'h10, 4'h0, 4'hF, 32'h12345678);
        flush = 1'b1;                 // dut_b write in WAIT
        #1;
        checks++;
        if (resp_b !== 1'b0 || busy_b !== 1'b1) begin
            errors++; $display("FAIL flush_wr_wait: resp=%b busy=%b, want 0/1", resp_b, busy_b);
        end
        tick();
        checks++;
        if (resp_b !== 1'b1) begin
            errors++; $display("FAIL flush_wr_resp: resp=%b, want 1", resp_b);
        end
        flush = 1'b0;
        idle(3);
        present(32'h10, 4'hF, 4'h0, 32'h0);
        idle(2);
        checks++;
        if (resp_b !== 1'b1 || rdata_b !== 32'h12345678) begin
            errors++; $display("FAIL flush_wr_readback: resp=%b rdata=%h, want 1/12345678", resp_b, rdata_b);
        end
        idle(3);
    endtask

    task automatic test_reset_mid_read();
        present(32'h40, 4'hF, 4'h0, 32'h0);
        rst = 1'b1;                   // dut_a in WAIT
        tick();
        rst = 1'b0;
        checks++;
        if (resp_a !== 1'b0 || busy_a !== 1'b0 || rdata_a !== 32'h0) begin
            errors++; $display("FAIL rst_mid: resp=%b busy=%b rdata=%h, want 0/0/0", resp_a, busy_a, rdata_a);
        end
        idle(2);
        present(32'h10, 4'hF, 4'h0, 32'h0);
        tick();
        checks++;
        if (resp_a !== 1'b1 || rdata_a !== 32'h12345678) begin
            errors++; $display("FAIL rst_fresh_read: resp=%b rdata=%h, want 1/12345678", resp_a, rdata_a);
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_merge();
        test_req_while_busy();
        test_flush_read();
        test_flush_write();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the out-of-order core's load/store path. It is the slave end of the `dmem_*` request/response protocol that the core's memory controller drives. It accepts one word-aligned read or byte-masked write at a time, holds it for a programmable latency, then returns a single-cycle `dmem_resp` with the full 32-bit word. It sits between the core's dmem port and on-chip SRAM, and doubles as the bench memory model for the load/store unit.

## Interface
- `ADDR_BITS`, default 10: log2 of storage depth in 32-bit words. Index is `dmem_addr[ADDR_BITS+1:2]`; higher address bits alias.
- `READ_LAT`, default 2: cycles from request-present to `dmem_resp` for reads. Legal range 1..15.
- `WRITE_LAT`, default 1: same for writes. Legal range 1..15.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: branch-mispredict flush from the core; cancels a pending read.
- `dmem_addr` in 32: byte address; bits [1:0] ignored for indexing.
- `dmem_rmask` in 4: nonzero = read request.
- `dmem_wmask` in 4: byte-enable write request.
- `dmem_wdata` in 32: write data, byte lanes aligned to the word.
- `dmem_rdata` out 32: full word read; meaningful only with `dmem_resp` on a read.
- `dmem_resp` out 1: one-cycle completion pulse for the accepted request.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- FSM with three states:
  - IDLE: the only state that samples requests.
  - WAIT: a 4-bit down-counter runs.
  - RESP: `dmem_resp`=1.
- Request present in IDLE means `dmem_wmask`!=0 or `dmem_rmask`!=0.
  - If both are nonzero, the request is a write and `dmem_rmask` is ignored.
- Write accept, at the IDLE edge:
  - For each byte i with `dmem_wmask[i]`=1, `mem[idx][8i+:8]` <= `dmem_wdata[8i+:8]`. Other bytes are unchanged.
  - Latency is `WRITE_LAT`; a kind bit records write.
- Read accept, at the IDLE edge:
  - `rdata_q` <= `mem[idx]`, the full word with no masking and no extension. The core extracts bytes/halves itself using `addr[1:0]`.
  - Latency is `READ_LAT`.
- State transitions from IDLE:
  - Latency L==1: IDLE -> RESP.
  - Otherwise: IDLE -> WAIT with cnt <= L-1.
- WAIT: cnt decrements each cycle; when cnt==1, go to RESP next.
- RESP -> IDLE unconditionally.
- Requests presented in WAIT or RESP are ignored and never queued. The core must hold off until it has seen `dmem_resp`.
- `dmem_rdata` = `rdata_q` in RESP for a read, else 32'h0.
- Storage is not cleared by reset; contents are undefined until written.
- Flush:
  - Flush in WAIT or RESP with a read pending: state goes to IDLE at the next edge. If flush coincides with RESP, `dmem_resp` is forced 0 that cycle, so no stale load data reaches the ROB.
  - Flush with a write pending: ignored. The write completes and responds normally, matching the core's rule that in-flight stores survive mispredicts.
  - Flush in IDLE with a read request in the same cycle: the read is not accepted.
  - Flush in IDLE with a write request in the same cycle: the write is accepted.

## Timing
- Reset values: state=IDLE, cnt=0, kind=read, `rdata_q`=0. Hence `dmem_resp`=0, `dmem_rdata`=0, `busy`=0.
- Reset mid-transaction: abandons it with no response. A write already committed to storage at accept stays committed.
- Request presented in IDLE at cycle T gives `dmem_resp` high for exactly cycle T+L.
  - `busy` is high for cycles T+1..T+L.
  - A new request is sampled no earlier than cycle T+L+1.
- Back-to-back throughput: one transaction per L+1 cycles.
- Read after write to the same word: the read returns the merged word. The write commits at the accept edge, before any later read can be accepted.
- All outputs are decoded from registered state. There is no combinational path from inputs to `dmem_resp` or `dmem_rdata`; `flush` gating of `dmem_resp` is the sole exception.

## Test plan
- Full-word write then read: `WRITE_LAT`=1, `READ_LAT`=2.
  - Write `addr`=0x40, `wmask`=4'hF, `wdata`=0xDEADBEEF -> `resp` one cycle later.
  - Then read `addr`=0x40, `rmask`=4'hF -> `resp` 2 cycles after present, `rdata`=0xDEADBEEF, `busy` high for 2 cycles.
- Byte-lane merge:
  - After the above, write `addr`=0x42, `wmask`=4'b0100, `wdata`=0x00AA0000.
  - Read `addr`=0x41 -> `rdata`=0xDEAABEEF.
- Request while busy:
  - Present a read; hold a second request on `addr`=0x80 during WAIT and RESP.
  - Exactly one `resp`; the second request is not serviced unless re-presented in IDLE.
- Flush on read:
  - `READ_LAT`=3, flush during WAIT -> no `resp`; IDLE next cycle; `busy`=0.
  - Repeat with flush in the RESP cycle -> `dmem_resp` stays 0.
- Flush on write:
  - Write `addr`=0x10 `wdata`=0x12345678 with flush asserted in WAIT -> `resp` still at T+`WRITE_LAT`.
  - A later read returns 0x12345678.
- Reset mid-read: assert `rst` in WAIT -> next cycle `dmem_resp`=0, `busy`=0, `dmem_rdata`=0. A fresh read completes normally.
